// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit and its scoreboard.
package hazard_pkg;

  // Operand source selects driven on fwd_sel_e
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  // Scoreboard counter value out of reset
  localparam logic [3:0] SB_CNT_RESET = 4'd0;

endpackage

// File: rtl/hazard_forward_unit_mul_scoreboard.sv
// Tracks the single in-flight multi-cycle op: whether it is pending, its
// destination register, and how many cycles remain before its W cycle.
module mul_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mulIssue,
  input  logic [AW-1:0] issueDst,
  output logic          busy,
  output logic [AW-1:0] dst,
  output logic          late
);

  logic [3:0] cnt;

  // Reload on issue (even in the W cycle of the previous op), else count down, else retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      dst  <= '0;
      cnt  <= SB_CNT_RESET;
    end else if (mulIssue) begin
      busy <= 1'b1;
      dst  <= issueDst;
      cnt  <= 4'(MUL_LAT - 1);
    end else if (busy) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  // With cnt==1 a consumer in D reaches E exactly in the W cycle, so only cnt>=2 blocks it
  assign late = busy && (cnt >= 4'd2);

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding for NSRC sources plus load-use / multi-cycle stall
// generation for the five-stage pipeline.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NSRC    = 2,
  parameter int AW      = 5,
  parameter int MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   src_reg_d,
  input  logic [AW-1:0]        dst_reg_d,
  input  logic                 reg_write_d,
  input  logic                 mul_d,
  input  logic [NSRC*AW-1:0]   src_reg_e,
  input  logic [NSRC*XLEN-1:0] rd_e,
  input  logic                 reg_write_e,
  input  logic                 mem_to_reg_e,
  input  logic [AW-1:0]        write_reg_e,
  input  logic                 mul_issue_e,
  input  logic                 reg_write_m,
  input  logic [AW-1:0]        write_reg_m,
  input  logic [XLEN-1:0]      alu_out_m,
  input  logic                 reg_write_w,
  input  logic [AW-1:0]        write_reg_w,
  input  logic [XLEN-1:0]      result_w,
  output logic [NSRC*XLEN-1:0] src_e,
  output logic [NSRC*2-1:0]    fwd_sel_e,
  output logic                 stall_d,
  output logic                 flush_e,
  output logic                 mul_busy
);

  logic          sbBusy;
  logic [AW-1:0] sbDst;
  logic          sbLate;
  logic [NSRC-1:0] loadUseHit;
  logic [NSRC-1:0] pendingHit;
  logic          loadUse;
  logic          rawPending;
  logic          structWaw;

  mul_scoreboard #(
    .AW      (AW),
    .MUL_LAT (MUL_LAT)
  ) uScoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .mulIssue (mul_issue_e),
    .issueDst (write_reg_e),
    .busy     (sbBusy),
    .dst      (sbDst),
    .late     (sbLate)
  );

  for (genvar i = 0; i < NSRC; i++) begin : gOperand
    logic [AW-1:0]   srcE;
    logic [AW-1:0]   srcD;
    logic [1:0]      sel;
    logic [XLEN-1:0] val;

    assign srcE = src_reg_e[i*AW +: AW];
    assign srcD = src_reg_d[i*AW +: AW];

    // Pick the youngest producer: M beats W, register 0 always reads the file
    always_comb begin
      sel = FWD_RF;
      val = rd_e[i*XLEN +: XLEN];
      if (reg_write_m && (write_reg_m == srcE) && (srcE != '0)) begin
        sel = FWD_M;
        val = alu_out_m;
      end else if (reg_write_w && (write_reg_w == srcE) && (srcE != '0)) begin
        sel = FWD_W;
        val = result_w;
      end
    end

    assign src_e[i*XLEN +: XLEN] = val;
    assign fwd_sel_e[i*2 +: 2]   = sel;
    assign loadUseHit[i]         = (srcD == write_reg_e);
    assign pendingHit[i]         = (srcD == sbDst);
  end

  assign loadUse    = mem_to_reg_e && reg_write_e && (write_reg_e != '0) && (|loadUseHit);
  assign rawPending = sbLate && (sbDst != '0) && (|pendingHit);
  assign structWaw  = sbLate && (mul_d || (reg_write_d && (dst_reg_d == sbDst) && (sbDst != '0)));

  assign stall_d  = loadUse || rawPending || structWaw;
  assign flush_e  = stall_d;
  assign mul_busy = sbBusy;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int AW = 5;
  localparam int MUL_LAT = 4;
  localparam logic [63:0] RD = {32'hBBBB_0001, 32'hAAAA_0000};

  logic clk = 1'b0;
  logic rstN;
  logic [NSRC*AW-1:0] srcRegD;
  logic [AW-1:0] dstRegD;
  logic regWriteD, mulD;
  logic [NSRC*AW-1:0] srcRegE;
  logic [NSRC*XLEN-1:0] rdE;
  logic regWriteE, memToRegE, mulIssueE;
  logic [AW-1:0] writeRegE;
  logic regWriteM;
  logic [AW-1:0] writeRegM;
  logic [XLEN-1:0] aluOutM;
  logic regWriteW;
  logic [AW-1:0] writeRegW;
  logic [XLEN-1:0] resultW;
  logic [NSRC*XLEN-1:0] srcE;
  logic [NSRC*2-1:0] fwdSelE;
  logic stallD, flushE, mulBusy;

  int nChecks = 0;
  int nPass = 0;

  // reference scoreboard: absolute edge index of the issue, result due MUL_LAT-1 cycles later
  int cycleNum = 0;
  bit mValid = 0;
  int mIssue = 0;
  int mDst = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rstN),
    .src_reg_d(srcRegD), .dst_reg_d(dstRegD), .reg_write_d(regWriteD), .mul_d(mulD),
    .src_reg_e(srcRegE), .rd_e(rdE), .reg_write_e(regWriteE), .mem_to_reg_e(memToRegE),
    .write_reg_e(writeRegE), .mul_issue_e(mulIssueE),
    .reg_write_m(regWriteM), .write_reg_m(writeRegM), .alu_out_m(aluOutM),
    .reg_write_w(regWriteW), .write_reg_w(writeRegW), .result_w(resultW),
    .src_e(srcE), .fwd_sel_e(fwdSelE), .stall_d(stallD), .flush_e(flushE), .mul_busy(mulBusy)
  );

  typedef struct {
    int sE0, sE1;
    logic [63:0] rd;
    int rwM, wrM;
    logic [31:0] aluM;
    int rwW, wrW;
    logic [31:0] resW;
    int sD0, sD1, ldE, rwE, wrE;
    logic [63:0] expSrc;
    int expSel;
    int expStall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNum);
  endtask

  task automatic clearIn();
    srcRegD = '0; dstRegD = '0; regWriteD = 0; mulD = 0;
    srcRegE = '0; rdE = RD; regWriteE = 0; memToRegE = 0; writeRegE = '0; mulIssueE = 0;
    regWriteM = 0; writeRegM = '0; aluOutM = '0;
    regWriteW = 0; writeRegW = '0; resultW = '0;
  endtask

  task automatic step();
    @(posedge clk);
    cycleNum++;
    if (rstN && mulIssueE) begin
      mValid = 1;
      mIssue = cycleNum;
      mDst = int'(writeRegE);
    end
    #1;
  endtask

  function automatic bit mBusy();
    return mValid && (cycleNum <= mIssue + MUL_LAT - 1);
  endfunction

  function automatic int mRemain();
    return mIssue + MUL_LAT - 1 - cycleNum;
  endfunction

  function automatic bit mLate();
    return mBusy() && (mRemain() >= 2);
  endfunction

  initial begin
    vecs[0]  = '{5, 6, RD, 1, 5, 32'h11,   1, 5, 32'h22, 0, 0, 0, 0, 0, {32'hBBBB_0001, 32'h11}, 4'b0010, 0};
    vecs[1]  = '{5, 6, RD, 0, 5, 32'h11,   1, 5, 32'h22, 0, 0, 0, 0, 0, {32'hBBBB_0001, 32'h22}, 4'b0001, 0};
    vecs[2]  = '{3, 0, RD, 1, 0, 32'hFFFF, 0, 0, 32'h0,  0, 0, 0, 0, 0, RD, 4'b0000, 0};
    vecs[3]  = '{4, 4, RD, 1, 7, 32'h99,   1, 4, 32'h33, 0, 0, 0, 0, 0, {32'h33, 32'h33}, 4'b0101, 0};
    vecs[4]  = '{2, 9, RD, 1, 9, 32'h44,   1, 2, 32'h55, 0, 0, 0, 0, 0, {32'h44, 32'h55}, 4'b1001, 0};
    vecs[5]  = '{0, 0, RD, 0, 0, 32'h0,    1, 0, 32'h77, 0, 0, 0, 0, 0, RD, 4'b0000, 0};
    vecs[6]  = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 1, 7, 1, 1, 7, RD, 0, 1};
    vecs[7]  = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 7, 2, 1, 1, 7, RD, 0, 1};
    vecs[8]  = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 3, 4, 1, 1, 7, RD, 0, 0};
    vecs[9]  = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 1, 0, RD, 0, 0};
    vecs[10] = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 0, 7, 0, 1, 7, RD, 0, 0};
    vecs[11] = '{0, 0, RD, 0, 0, 32'h0, 0, 0, 32'h0, 7, 0, 1, 0, 7, RD, 0, 0};

    // reset: combinational paths live, scoreboard held empty even with an issue
    clearIn();
    rstN = 0;
    srcRegE = {5'd0, 5'd5}; regWriteM = 1; writeRegM = 5'd5; aluOutM = 32'h11;
    mulIssueE = 1; writeRegE = 5'd9;
    #2;
    chk("rst_busy", 64'(mulBusy), 64'd0);
    chk("rst_fwd_sel", 64'(fwdSelE), 64'b0010);
    step();
    chk("rst_issue_ignored", 64'(mulBusy), 64'd0);
    @(negedge clk);
    clearIn();
    rstN = 1;
    step();

    // table-driven combinational vectors
    for (int k = 0; k < 12; k++) begin
      clearIn();
      srcRegE = {5'(vecs[k].sE1), 5'(vecs[k].sE0)};
      rdE = vecs[k].rd;
      regWriteM = 1'(vecs[k].rwM); writeRegM = 5'(vecs[k].wrM); aluOutM = vecs[k].aluM;
      regWriteW = 1'(vecs[k].rwW); writeRegW = 5'(vecs[k].wrW); resultW = vecs[k].resW;
      srcRegD = {5'(vecs[k].sD1), 5'(vecs[k].sD0)};
      memToRegE = 1'(vecs[k].ldE); regWriteE = 1'(vecs[k].rwE); writeRegE = 5'(vecs[k].wrE);
      #1;
      chk($sformatf("vec%0d_src", k), 64'(srcE), vecs[k].expSrc);
      chk($sformatf("vec%0d_sel", k), 64'(fwdSelE), 64'(vecs[k].expSel));
      chk($sformatf("vec%0d_stall", k), 64'(stallD), 64'(vecs[k].expStall));
      chk($sformatf("vec%0d_flush", k), 64'(flushE), 64'(vecs[k].expStall));
      step();
    end

    // load-use: one stall cycle, then the consumer forwards from M
    clearIn();
    memToRegE = 1; regWriteE = 1; writeRegE = 5'd7; srcRegD = {5'd7, 5'd0};
    #1;
    chk("lu_stall", 64'(stallD), 64'd1);
    chk("lu_flush", 64'(flushE), 64'd1);
    step();
    clearIn();
    regWriteM = 1; writeRegM = 5'd7; aluOutM = 32'h7777; srcRegE = {5'd7, 5'd0};
    #1;
    chk("lu_after_stall", 64'(stallD), 64'd0);
    chk("lu_fwd_sel", 64'(fwdSelE), 64'b1000);
    chk("lu_fwd_val", 64'(srcE[63:32]), 64'h7777);

    // multi-cycle RAW
    clearIn();
    mulIssueE = 1; writeRegE = 5'd9;
    step();
    clearIn();
    srcRegD = {5'd0, 5'd9};
    #1;
    chk("raw_t_stall", 64'(stallD), 64'd1);
    chk("raw_t_flush", 64'(flushE), 64'd1);
    chk("raw_t_busy", 64'(mulBusy), 64'd1);
    step();
    chk("raw_t1_stall", 64'(stallD), 64'd1);
    step();
    chk("raw_t2_stall", 64'(stallD), 64'd0);
    step();
    clearIn();
    srcRegE = {5'd0, 5'd9}; regWriteW = 1; writeRegW = 5'd9; resultW = 32'hCAFE_0009;
    #1;
    chk("raw_t3_val", 64'(srcE[31:0]), 64'hCAFE_0009);
    chk("raw_t3_sel", 64'(fwdSelE), 64'b0001);
    chk("raw_t3_busy", 64'(mulBusy), 64'd1);
    step();
    clearIn();
    #1;
    chk("raw_t4_busy", 64'(mulBusy), 64'd0);

    // back-to-back multi-cycle ops
    clearIn();
    mulIssueE = 1; writeRegE = 5'd9;
    step();
    clearIn();
    mulD = 1;
    #1;
    chk("b2b_t_stall", 64'(stallD), 64'd1);
    step();
    chk("b2b_t1_stall", 64'(stallD), 64'd1);
    step();
    chk("b2b_t2_stall", 64'(stallD), 64'd0);
    step();
    clearIn();
    mulIssueE = 1; writeRegE = 5'd10;
    #1;
    chk("b2b_t3_busy", 64'(mulBusy), 64'd1);
    step();
    clearIn();
    chk("b2b_t4_busy", 64'(mulBusy), 64'd1);
    srcRegD = {5'd0, 5'd10};
    #1;
    chk("b2b_new_dst_stall", 64'(stallD), 64'd1);
    srcRegD = {5'd0, 5'd9};
    #1;
    chk("b2b_old_dst_free", 64'(stallD), 64'd0);
    clearIn();
    repeat (4) step();
    chk("b2b_drained", 64'(mulBusy), 64'd0);

    // reset mid-operation abandons the pending result
    clearIn();
    mulIssueE = 1; writeRegE = 5'd9;
    step();
    clearIn();
    step();
    chk("rmid_busy_before", 64'(mulBusy), 64'd1);
    #2;
    rstN = 0;
    #1;
    chk("rmid_busy_async", 64'(mulBusy), 64'd0);
    @(negedge clk);
    rstN = 1;
    srcRegD = {5'd0, 5'd9};
    #1;
    chk("rmid_no_stall", 64'(stallD), 64'd0);
    step();
    chk("rmid_no_stall_next", 64'(stallD), 64'd0);
    chk("rmid_busy_after", 64'(mulBusy), 64'd0);

    // randomized traffic against the reference model
    mValid = 0;
    for (int n = 0; n < 400; n++) begin
      logic [63:0] eSrc;
      logic [3:0] eSel;
      bit eStall, lu, anyPend;
      srcRegD = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      dstRegD = 5'($urandom_range(0, 3));
      regWriteD = 1'($urandom_range(0, 1));
      mulD = ($urandom_range(0, 5) == 0);
      srcRegE = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rdE = {$urandom, $urandom};
      regWriteE = 1'($urandom_range(0, 1));
      memToRegE = ($urandom_range(0, 2) == 0);
      writeRegE = 5'($urandom_range(0, 3));
      mulIssueE = (!mBusy() || mRemain() == 0) && ($urandom_range(0, 3) == 0);
      regWriteM = 1'($urandom_range(0, 1)); writeRegM = 5'($urandom_range(0, 3)); aluOutM = $urandom;
      regWriteW = 1'($urandom_range(0, 1)); writeRegW = 5'($urandom_range(0, 3)); resultW = $urandom;
      #1;
      lu = 0; anyPend = 0;
      for (int i = 0; i < NSRC; i++) begin
        int s, sd;
        s = int'(srcRegE[i*AW +: AW]);
        sd = int'(srcRegD[i*AW +: AW]);
        if (regWriteM && int'(writeRegM) == s && s != 0) begin
          eSrc[i*32 +: 32] = aluOutM; eSel[i*2 +: 2] = 2'd2;
        end else if (regWriteW && int'(writeRegW) == s && s != 0) begin
          eSrc[i*32 +: 32] = resultW; eSel[i*2 +: 2] = 2'd1;
        end else begin
          eSrc[i*32 +: 32] = rdE[i*32 +: 32]; eSel[i*2 +: 2] = 2'd0;
        end
        if (sd == int'(writeRegE)) lu = 1;
        if (sd == mDst) anyPend = 1;
      end
      eStall = (memToRegE && regWriteE && writeRegE != 0 && lu)
            || (mLate() && mDst != 0 && anyPend)
            || (mLate() && (mulD || (regWriteD && int'(dstRegD) == mDst && mDst != 0)));
      chk("rnd_src", 64'(srcE), eSrc);
      chk("rnd_sel", 64'(fwdSelE), 64'(eSel));
      chk("rnd_stall", 64'(stallD), 64'(eStall));
      chk("rnd_flush", 64'(flushE), 64'(eStall));
      chk("rnd_busy", 64'(mulBusy), 64'(mBusy()));
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
